// File: rtl/iq_grab_pkg.sv
// Shared constants and slot-index helpers for the I/Q stream grabber.
// Holds no logic.
// Nothing here involves timing or flow control.
package iq_grab_pkg;

  // Width of the saturating short-frame counter
  localparam int ERR_CNT_W = 8;

  // Slot counter width for a frame of 2*n_ch words
  function automatic int slot_w(input int n_ch);
    return (n_ch > 0) ? $clog2(2 * n_ch) : 1;
  endfunction

  // Position of channel ch's I (is_q=0) or Q (is_q=1) word within a frame
  function automatic int iq_slot(input int ch, input bit is_q);
    return 2 * ch + (is_q ? 1 : 0);
  endfunction

endpackage

// File: rtl/iq_grab_accum.sv
// Sums one frame word over 2**LOG_AVG complete frames; o_avg is the average of the window including i_din.
// Latency: o_avg is combinational from i_din; the running sum updates on the clock edge where i_add is high.
// No backpressure: adds whenever i_add is high, and i_restart empties the sum for the next window.
module iq_grab_accum #(
  parameter int DW      = 30,
  parameter int LOG_AVG = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_add,
  input  logic          i_restart,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_avg
);
  localparam int AW = DW + LOG_AVG;

  logic signed [AW-1:0] r_acc;
  logic signed [AW-1:0] w_din_ext;
  logic signed [AW-1:0] w_sum;

  assign w_din_ext = AW'($signed(i_din));
  assign w_sum     = r_acc + w_din_ext;
  // Arithmetic shift rounds toward -inf; the quotient always fits back in DW bits
  assign o_avg     = DW'(w_sum >>> LOG_AVG);

  // Accumulate complete frames; the final frame of a window leaves the sum empty for the next one
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= i_restart ? '0 : w_sum;
    end
  end

endmodule

// File: rtl/iq_stream_grabber.sv
// Deserialises a time-multiplexed I0,Q0..I(N-1),Q(N-1) word stream into parallel per-channel registers.
// Latency: strobe_out and new i_out/q_out appear 1 cycle after the last word of a frame is accepted.
// No backpressure: every strobe_in word is taken, and a frame cut short is dropped and counted. Averaging: IQ_GRAB_AVG_EN.
module iq_stream_grabber
  import iq_grab_pkg::*;
#(
  parameter int DW      = 30,
  parameter int N_CH    = 4,
  parameter int LOG_AVG = 4
) (
  input  logic                 sample_clk,
  input  logic                 sample_rst,
  input  logic [DW-1:0]        stream_in,
  input  logic                 strobe_in,
  input  logic                 err_clr,
  output logic [N_CH*DW-1:0]   i_out,
  output logic [N_CH*DW-1:0]   q_out,
  output logic                 strobe_out,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);
  localparam int            NW        = 2 * N_CH;
  localparam int            SW        = slot_w(N_CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NW - 1);

  logic [SW-1:0]        r_slot;
  // The last word of a frame is used straight from stream_in, so it needs no shadow register
  logic [DW-1:0]        r_shadow [NW-1];
  logic [DW-1:0]        w_word   [NW];
  logic [DW-1:0]        w_res    [NW];
  logic                 w_last;
  logic                 w_short;
  logic                 w_emit;
  logic [ERR_CNT_W-1:0] w_cnt_base;

  assign w_last     = strobe_in && (r_slot == LAST_SLOT);
  assign w_short    = !strobe_in && (r_slot != '0);
  // An err_clr in the same cycle as a short frame restarts the count before it is incremented
  assign w_cnt_base = err_clr ? '0 : err_cnt;

  // Slot position: advance per accepted word, wrap after the last one, fall back to 0 when the strobe drops
  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      r_slot <= '0;
    end else if (w_last || !strobe_in) begin
      r_slot <= '0;
    end else begin
      r_slot <= r_slot + 1'b1;
    end
  end

  // Capture every word of the frame in progress except the last one
  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      for (int s = 0; s < NW - 1; s++) r_shadow[s] <= '0;
    end else begin
      for (int s = 0; s < NW - 1; s++) begin
        if (strobe_in && (r_slot == SW'(s))) r_shadow[s] <= stream_in;
      end
    end
  end

  // Complete-frame view: the shadow registers plus the word arriving now
  always_comb begin
    for (int s = 0; s < NW - 1; s++) w_word[s] = r_shadow[s];
    w_word[NW-1] = stream_in;
  end

`ifdef IQ_GRAB_AVG_EN
  localparam int             FCW       = LOG_AVG + 1;
  localparam logic [FCW-1:0] FRAMES_M1 = FCW'((1 << LOG_AVG) - 1);

  logic [FCW-1:0] r_fcnt;
  logic           w_final;

  assign w_final = w_last && (r_fcnt == FRAMES_M1);
  assign w_emit  = w_final;

  // Count complete frames in the current averaging window; short frames never reach w_last
  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      r_fcnt <= '0;
    end else if (w_last) begin
      r_fcnt <= w_final ? '0 : r_fcnt + 1'b1;
    end
  end

  for (genvar gs = 0; gs < NW; gs++) begin : g_acc
    iq_grab_accum #(
      .DW      (DW),
      .LOG_AVG (LOG_AVG)
    ) u_acc (
      .i_clk     (sample_clk),
      .i_rst     (sample_rst),
      .i_add     (w_last),
      .i_restart (w_final),
      .i_din     (w_word[gs]),
      .o_avg     (w_res[gs])
    );
  end
`else
  assign w_emit = w_last;

  // Without averaging, each complete frame is published as-is
  always_comb begin
    for (int s = 0; s < NW; s++) w_res[s] = w_word[s];
  end

  // LOG_AVG only shapes the averaging build; this build has no window length
  if (LOG_AVG > 8) begin : g_log_avg_unused
  end
`endif

  // Publish a finished frame (or window average) and raise the one-cycle strobe
  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      i_out      <= '0;
      q_out      <= '0;
      strobe_out <= 1'b0;
    end else begin
      strobe_out <= w_emit;
      if (w_emit) begin
        for (int k = 0; k < N_CH; k++) begin
          i_out[k*DW +: DW] <= w_res[iq_slot(k, 1'b0)];
          q_out[k*DW +: DW] <= w_res[iq_slot(k, 1'b1)];
        end
      end
    end
  end

  // Sticky short-frame flag and saturating counter; a short frame outranks err_clr
  always_ff @(posedge sample_clk) begin
    if (sample_rst) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else if (w_short) begin
      frame_err <= 1'b1;
      err_cnt   <= (&w_cnt_base) ? w_cnt_base : w_cnt_base + 1'b1;
    end else if (err_clr) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end
  end

endmodule
